// File: rtl/lcd1602_pkg.sv
// rtl/lcd1602_pkg.sv - shared LCD1602 opcodes, address map and ac helpers
package lcd1602_pkg;

  localparam logic [6:0] LINE1_BASE   = 7'h00;
  localparam logic [6:0] LINE2_BASE   = 7'h40;
  localparam int         LINE_LEN     = 16;
  localparam logic [6:0] AC_LINE_END  = 7'h27;
  localparam logic [6:0] AC_LINE2_END = 7'h67;

  // Instruction class is the highest set bit of the byte
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [1:0] {
    ST_RESET_CLR,
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Address is inside one of the two DDRAM line windows
  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= AC_LINE_END) || ((a >= LINE2_BASE) && (a <= AC_LINE2_END));
  endfunction

  // Address falls in the 16 visible columns of either line
  function automatic logic ac_on_screen(input logic [6:0] a);
    return (a[6:4] == LINE1_BASE[6:4]) || (a[6:4] == LINE2_BASE[6:4]);
  endfunction

  // Visible address to frame-buffer index: line 2 lands at LINE_LEN + column
  function automatic logic [4:0] ac_to_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // One step of the address counter with the two-line wrap rules
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == AC_LINE_END)       return LINE2_BASE;
      else if (a == AC_LINE2_END) return LINE1_BASE;
      else                        return a + 7'd1;
    end else begin
      if (a == LINE1_BASE)        return AC_LINE2_END;
      else if (a == LINE2_BASE)   return AC_LINE_END;
      else                        return a - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd1602_ddram.sv
// rtl/lcd1602_ddram.sv - 32x8 frame buffer, one write port, registered read port
module lcd1602_ddram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [32];
  logic [7:0] rdata_q;

  // Synchronous write; contents are not reset, the post-reset clear fills them
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to raddr is seen one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= 8'h00;
    else     rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd1602_responder.sv
// rtl/lcd1602_responder.sv - HD44780-style write-bus responder with frame buffer
module lcd1602_responder
  import lcd1602_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       two_line,
  output logic       busy,
  output logic       wr_strobe,
  output logic       cmd_err
);

  logic [SYNC_STAGES-1:0] en_sync_q;
  logic                   en_prev_q;
  logic [9:0]             bus_dly_q [SYNC_STAGES];

  state_e     state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [6:0] ac_q, ac_d;
  logic       disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic       inc_q, inc_d, two_line_q, two_line_d;
  logic       strobe_q, strobe_d, err_q, err_d;

  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic       fall;
  logic       bus_rs, bus_rw;
  logic [7:0] bus_data;

  // Enable synchroniser with rs/rw/data delayed by the same depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sync_q <= '0;
      en_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) bus_dly_q[i] <= '0;
    end else begin
      en_sync_q    <= {en_sync_q[SYNC_STAGES-2:0], lcd_en};
      en_prev_q    <= en_sync_q[SYNC_STAGES-1];
      bus_dly_q[0] <= {lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) bus_dly_q[i] <= bus_dly_q[i-1];
    end
  end

  assign fall = en_prev_q & ~en_sync_q[SYNC_STAGES-1];
  assign {bus_rs, bus_rw, bus_data} = bus_dly_q[SYNC_STAGES-1];

  // State, address counter, mode flags and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET_CLR;
      clr_idx_q  <= 5'd0;
      ac_q       <= 7'h00;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      inc_q      <= 1'b1;
      two_line_q <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ac_q       <= ac_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      inc_q      <= inc_d;
      two_line_q <= two_line_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  // Clear sequencing plus instruction/data decode of each committed fall
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ac_d       = ac_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    inc_d      = inc_q;
    two_line_d = two_line_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_idx_q;
    mem_wdata  = CLEAR_CHAR;

    case (state_q)
      ST_RESET_CLR, ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (fall && !bus_rw) begin
      if (state_q != ST_IDLE) begin
        err_d = 1'b1;
      end else if (bus_rs) begin
        strobe_d = 1'b1;
        if (ac_on_screen(ac_q)) begin
          mem_we    = 1'b1;
          mem_waddr = ac_to_index(ac_q);
          mem_wdata = bus_data;
        end
        ac_d = ac_step(ac_q, inc_q);
      end else begin
        strobe_d = 1'b1;
        if (|(bus_data & OP_SET_DDRAM)) begin
          if (ac_valid(bus_data[6:0])) ac_d = bus_data[6:0];
          else begin
            err_d    = 1'b1;
            strobe_d = 1'b0;
          end
        end else if (|(bus_data & OP_SET_CGRAM)) begin
          // CGRAM is not modelled; ac keeps pointing at DDRAM
        end else if (|(bus_data & OP_FUNC_SET)) begin
          two_line_d = bus_data[3];
        end else if (|(bus_data & OP_SHIFT)) begin
          if (!bus_data[3]) ac_d = ac_step(ac_q, bus_data[2]);
        end else if (|(bus_data & OP_DISP_CTRL)) begin
          {disp_d, cursor_d, blink_d} = bus_data[2:0];
        end else if (|(bus_data & OP_ENTRY)) begin
          inc_d = bus_data[1];
        end else if (|(bus_data & OP_HOME)) begin
          ac_d = LINE1_BASE;
        end else if (|(bus_data & OP_CLEAR)) begin
          ac_d    = LINE1_BASE;
          inc_d   = 1'b1;
          state_d = ST_CLEAR;
        end
      end
    end
  end

  lcd1602_ddram u_ddram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign ac        = ac_q;
  assign disp_on   = disp_q;
  assign cursor_on = cursor_q;
  assign blink_on  = blink_q;
  assign inc_mode  = inc_q;
  assign two_line  = two_line_q;
  assign busy      = (state_q != ST_IDLE);
  assign wr_strobe = strobe_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_lcd1602_responder.sv
// tb/tb_lcd1602_responder.sv - scoreboard bench for lcd1602_responder
module tb_lcd1602_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_en = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, inc_mode, two_line, busy, wr_strobe, cmd_err;

  localparam logic [1:0] EV_OK  = 2'b10;
  localparam logic [1:0] EV_ERR = 2'b01;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] exp_q [$];

  lcd1602_responder dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ac        (ac),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .inc_mode  (inc_mode),
    .two_line  (two_line),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each strobe/error pulse is matched against the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (wr_strobe || cmd_err)) begin
      if (exp_q.size() == 0) check("unexpected_pulse", {30'd0, wr_strobe, cmd_err}, 32'd0);
      else                   check("pulse", {30'd0, wr_strobe, cmd_err}, {30'd0, exp_q.pop_front()});
    end
  end

  task automatic bus(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, input logic [1:0] ev);
    exp_q.push_back(ev);
    bus(rs, 1'b0, d);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = idx[4:0];
    @(negedge clk);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic chk_all(input logic [7:0] exp);
    for (int i = 0; i < 32; i++) rd_chk("buf_fill", i, exp);
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_ac", {25'd0, ac}, 0);
    check("rst_flags", {26'd0, disp_on, cursor_on, blink_on, inc_mode, two_line, busy}, 32'b000101);
    check("rst_pulses", {30'd0, wr_strobe, cmd_err}, 0);
    check("rst_rd_data", {24'd0, rd_data}, 0);
    rst = 1'b0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", n, 32);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] x;

    do_reset();
    chk_all(8'h20);
    check("ac_after_clear", {25'd0, ac}, 0);

    wr(1'b0, 8'hFF, EV_ERR);
    check("ac_bad_addr", {25'd0, ac}, 0);
    wr(1'b0, 8'h01, EV_OK);
    wait_idle();
    wr(1'b0, 8'h02, EV_OK);
    wr(1'b0, 8'h06, EV_OK);
    wr(1'b0, 8'h0C, EV_OK);
    wr(1'b0, 8'h14, EV_OK);
    check("shift_right", {25'd0, ac}, 32'h01);
    wr(1'b0, 8'h38, EV_OK);
    wr(1'b0, 8'h80, EV_OK);
    wr(1'b1, 8'h41, EV_OK);
    check("mode_flags", {28'd0, disp_on, cursor_on, inc_mode, two_line}, 32'b1011);
    check("blink", {31'd0, blink_on}, 0);
    rd_chk("buf0", 0, 8'h41);
    check("ac_after_A", {25'd0, ac}, 32'h01);

    wr(1'b0, 8'h8F, EV_OK);
    wr(1'b1, 8'h5A, EV_OK);
    wr(1'b1, 8'h5B, EV_OK);
    rd_chk("buf15", 15, 8'h5A);
    rd_chk("buf16_unstored", 16, 8'h20);
    check("ac_0x11", {25'd0, ac}, 32'h11);
    wr(1'b0, 8'hC0, EV_OK);
    wr(1'b1, 8'h31, EV_OK);
    rd_chk("buf16", 16, 8'h31);
    check("ac_0x41", {25'd0, ac}, 32'h41);

    wr(1'b0, 8'hA7, EV_OK);
    x = 8'($urandom_range(0, 255));
    wr(1'b1, x, EV_OK);
    check("wrap_27_40", {25'd0, ac}, 32'h40);
    wr(1'b0, 8'hE7, EV_OK);
    x = 8'($urandom_range(0, 255));
    wr(1'b1, x, EV_OK);
    check("wrap_67_00", {25'd0, ac}, 32'h00);
    wr(1'b0, 8'h04, EV_OK);
    check("inc_mode_0", {31'd0, inc_mode}, 0);
    wr(1'b0, 8'hC0, EV_OK);
    x = 8'($urandom_range(0, 255));
    wr(1'b1, x, EV_OK);
    check("wrap_40_27", {25'd0, ac}, 32'h27);
    wr(1'b0, 8'h80, EV_OK);
    wr(1'b1, 8'h41, EV_OK);
    check("wrap_00_67", {25'd0, ac}, 32'h67);
    wr(1'b0, 8'hA8, EV_ERR);
    check("bad_addr_keep", {25'd0, ac}, 32'h67);
    wr(1'b0, 8'h14, EV_OK);
    check("shift_r_wrap", {25'd0, ac}, 32'h00);
    wr(1'b0, 8'h10, EV_OK);
    check("shift_l_wrap", {25'd0, ac}, 32'h67);

    bus(1'b1, 1'b1, 8'h99);
    check("rw_ac", {25'd0, ac}, 32'h67);
    rd_chk("rw_buf0", 0, 8'h41);

    wr(1'b0, 8'h01, EV_OK);
    wr(1'b1, 8'h77, EV_ERR);
    wait_idle();
    chk_all(8'h20);
    check("clr_ac", {25'd0, ac}, 0);
    check("clr_inc", {31'd0, inc_mode}, 1);

    wr(1'b0, 8'hCF, EV_OK);
    wr(1'b1, 8'h55, EV_OK);
    rd_chk("buf31", 31, 8'h55);
    wr(1'b0, 8'h01, EV_OK);
    repeat (5) @(negedge clk);
    do_reset();
    chk_all(8'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- HD44780-compatible bus responder: the receiving end of the 8-bit LCD1602 write bus that our LCD master drives (EN/RS/RW/DATA).
- Decodes instruction and data writes and maintains the address counter, mode flags and a 32-character visible frame buffer.
- Exposes the frame buffer through a registered read port, so the displayed text can be mirrored to UART/VGA or checked in simulation without a physical panel.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on lcd_en (and on the aligned rs/rw/data pipeline)
- CLEAR_CHAR, 8'h20, fill value written by Clear Display and by the post-reset clear

Ports:
- clk  in  1  system clock; frequency must be at least 4x the lcd_en frequency
- rst  in  1  asynchronous, active-high reset
- lcd_en  in  1  LCD enable; a write is latched on its falling edge
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read; read cycles are ignored
- lcd_data  in  8  bus data
- rd_addr  in  5  frame-buffer read index: 0-15 is line 1, 16-31 is line 2
- rd_data  out  8  character at rd_addr, one cycle latency
- ac  out  7  current DDRAM address counter
- disp_on, cursor_on, blink_on  out  1 each  Display On/Off control bits D, C, B
- inc_mode  out  1  Entry Mode I/D bit
- two_line  out  1  Function Set N bit
- busy  out  1  clear sequence in progress
- wr_strobe  out  1  one-cycle pulse per accepted transaction
- cmd_err  out  1  one-cycle pulse on an invalid address or on a write dropped while busy

Behaviour:
- Reset values: ac=0, disp_on=0, cursor_on=0, blink_on=0, inc_mode=1, two_line=0, wr_strobe=0, cmd_err=0, rd_data=0.
- busy=1 during reset. On reset release the block runs CLEAR (32 cycles), then busy=0.
- Input capture:
  - lcd_en passes through SYNC_STAGES flops.
  - rs/rw/data are delayed by the same depth so they stay aligned with the synchronised enable.
  - A fall is a synchronised 1->0 transition.
  - The fall commits on the next clk edge, with wr_strobe high for that cycle.
  - rw=1 falls are ignored: no strobe, no state change.
- Instruction decode (rs=0), by highest set bit:
  - 1aaaaaaa Set DDRAM addr: valid ranges are 0x00-0x27 and 0x40-0x67. Otherwise ac is unchanged and cmd_err pulses.
  - 01xxxxxx Set CGRAM addr: accepted, no effect; the next data write goes to DDRAM at ac.
  - 001DNFxx Function Set: two_line<=N.
  - 0001SRxx: S=0 moves ac by one, right if R=1 and left if R=0, using the wrap rules below. S=1 (display shift) is a no-op.
  - 00001DCB: disp_on/cursor_on/blink_on update.
  - 000001IS: inc_mode<=I; S is ignored.
  - 0000001x Return Home: ac<=0.
  - 00000001 Clear: ac<=0, inc_mode<=1, busy<=1, and buffer indices 0..31 are written with CLEAR_CHAR, one per cycle (32 cycles).
  - 00000000: no-op.
- Data write (rs=1):
  - Byte is stored if ac is in 0x00-0x0F (index ac) or 0x40-0x4F (index 16+ac-0x40). Other valid addresses are accepted but not stored.
  - ac then steps per inc_mode.
- ac wrap, two-line map:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
- While busy, any non-ignored fall is dropped with cmd_err=1 and wr_strobe=0.
- Reset mid-clear: the clear restarts from index 0 after reset release.
- Read port: rd_data <= buf[rd_addr] every cycle. A same-cycle write to the same index returns the old value.

Decomposition:
- Shared package lcd1602_pkg holds:
  - Instruction opcode masks.
  - LINE1_BASE=7'h00, LINE2_BASE=7'h40, LINE_LEN=16, AC_LINE_END=7'h27.
  - The ac-to-index mapping function, shared with the master-side bench.
- One sub-module, lcd1602_ddram: 32x8, one synchronous write port, one registered read port.
- The FSM (RESET_CLR, IDLE, CLEAR) and the decode stay in the top level.

Test Plan:
- Reset release -> busy=1 for 32 cycles; then every rd_addr 0..31 returns 8'h20 and ac=0.
- Master sequence 0xFF, 0x01, 0x02, 0x06, 0x0C, 0x14, 0x38, then 0x80 + data 0x41:
  - 0xFF gives cmd_err.
  - After the sequence: disp_on=1, cursor_on=0, inc_mode=1, two_line=1.
  - buf[0]=0x41 and ac=0x01.
- 0x8F, data 0x5A, data 0x5B -> buf[15]=0x5A; ac=0x11 and 0x5B is not stored. Then 0xC0 + data 0x31 -> buf[16]=0x31, ac=0x41.
- 0xA7, data x -> ac=0x40. 0xE7, data x -> ac=0x00. Entry 0x04 at 0xC0 with one write -> ac=0x27.
- 0x01 followed by a data write 4 cycles later -> write dropped, cmd_err pulse, buffer all 8'h20 after 32 cycles. rst asserted mid-clear -> clear restarts after release.
- Fall with lcd_rw=1 -> no wr_strobe, ac and buffer unchanged.
